pc_stack: RTL and testbench
===========================

# pc_stack

Parametrised program counter with a hardware return-address stack, signed relative branch and configurable increment stride. It generalises the 16-bit reset/load/increment counter to any width and adds subroutine call/return with overflow and underflow detection. It sits in the CPU fetch stage: `out` drives the instruction-memory address, and control inputs come from the decode stage.

## Interface
- `WIDTH`, 16, PC and data width in bits (≥ 2)
- `DEPTH`, 8, return-stack entries (≥ 2)
- `STEP`, 1, increment added by `inc` and pushed as the return offset by `call` (1 ≤ STEP < 2^WIDTH)

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low; low clears all state immediately
- `load`  in  1  absolute jump: `out` ← `d_in`
- `call`  in  1  push `out`+STEP, then `out` ← `d_in`
- `ret`  in  1  `out` ← top of stack, then pop
- `branch`  in  1  relative jump: `out` ← `out` + `offset`
- `inc`  in  1  `out` ← `out` + STEP
- `clear_err`  in  1  clears the sticky error flags
- `d_in`  in  WIDTH  jump target for `load`/`call`
- `offset`  in  WIDTH  two's-complement branch displacement
- `out`  out  WIDTH  current PC (registered)
- `sp`  out  $clog2(DEPTH+1)  number of valid stack entries (registered)
- `empty`  out  1  `sp`==0
- `full`  out  1  `sp`==DEPTH
- `overflow`  out  1  sticky; a `call` occurred while full
- `underflow`  out  1  sticky; a `ret` occurred while empty

## Operation
- Reset (`reset`=0, asynchronous): `out`=0, `sp`=0, `overflow`=0, `underflow`=0, so `empty`=1 and `full`=0. Stack RAM contents are not reset and are never observable while `sp` is 0.
- Each rising edge applies exactly one command, in fixed priority: `load` > `call` > `ret` > `branch` > `inc` > hold. Lower-priority commands asserted in the same cycle are ignored.
- `load`: `out` ← `d_in`. The stack is untouched.
- `call`, not full: `stack[sp]` ← `out`+STEP (mod 2^WIDTH); `sp` ← `sp`+1; `out` ← `d_in`.
- `call` while full: `out` ← `d_in`; no push; `sp` unchanged; `overflow` ← 1.
- `ret`, not empty: `out` ← `stack[sp-1]`; `sp` ← `sp`-1.
- `ret` while empty: `out` holds; `sp` stays 0; `underflow` ← 1.
- `branch`: `out` ← (`out` + `offset`) mod 2^WIDTH. Negative offsets wrap below 0.
- `inc`: `out` ← (`out` + STEP) mod 2^WIDTH. For example, 0xFFFF + 1 = 0x0000 at WIDTH 16.
- Hold (no command asserted): all state is unchanged.
- `clear_err` clears `overflow` and `underflow` on the edge. If a new error occurs in the same cycle, the set wins and the flag reads 1.
- `empty` and `full` are decoded combinationally from registered `sp` and are glitch-free relative to `clk`.
- All arithmetic is unsigned modulo 2^WIDTH. No carry-out is exported.

## Timing
- Single-cycle latency: every command's effect is visible on `out`, `sp` and the flags after the rising edge that samples it.
- A `call` followed immediately by a `ret` on the next edge returns to the pushed address. No bubbles are required.
- Back-to-back calls up to DEPTH are accepted on consecutive edges. Back-to-back returns likewise.
- Reset asserted in mid-sequence clears state asynchronously, with no clock needed. Deassertion is synchronised externally, and the first command is taken on the first rising edge after `reset` goes high.
- Inputs must be stable around the rising edge of `clk`. There are no combinational paths from inputs to `out` or `sp`.

## Test plan
1. Reset, then hold: pulse `reset` low mid-cycle with `load`=1, `d_in`=1123 → `out`=0, `sp`=0, `empty`=1 immediately and after the next edge while `reset`=0.
2. Increment and wrap (WIDTH=16, STEP=1): load 0xFFFE, then `inc` for 3 edges → `out` = 0xFFFF, 0x0000, 0x0001.
3. Call/return: `out`=100, `call` with `d_in`=5678 → `out`=5678, `sp`=1. `inc` twice → 5680. `ret` → `out`=101, `sp`=0, `empty`=1.
4. Stack limits (DEPTH=8): 9 consecutive calls → `sp`=8, `full`=1, `overflow`=1 after the 9th, and `out` equals the 9th `d_in`. Then 9 returns → the first 8 pop in LIFO order, the 9th sets `underflow`=1 and `out` holds. `clear_err` → both flags 0.
5. Branch: `out`=10, `offset`=0xFFFD (−3) → `out`=7. Then `offset`=0x7FF0 from 0x9000 → wraps to 0x0FF0.
6. Priority: `load`, `call`, `ret`, `inc` all high with `d_in`=9876 and `sp`=2 → `out`=9876, `sp` stays 2. Then `ret`+`branch`+`inc` → pop wins. `ret`+`clear_err` while empty → `underflow` stays 1.

Source files
------------

// File: rtl/pc_stack.sv
// Fetch-stage program counter with a hardware return-address stack.
// Fixed-priority command decode: load > call > ret > branch > inc > hold.
module pc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int STEP  = 1,
  localparam int SPW  = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             call,
  input  logic             ret,
  input  logic             branch,
  input  logic             inc,
  input  logic             clear_err,
  input  logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] out,
  output logic [SPW-1:0]   sp,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic [2:0] {
    C_HOLD, C_LOAD, C_CALL, C_RET, C_BRANCH, C_INC
  } cmd_e;

  cmd_e             cmd;
  logic             push, pop;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [WIDTH-1:0] stack [DEPTH];

  always_comb begin
    cmd = C_HOLD;
    if (load)        cmd = C_LOAD;
    else if (call)   cmd = C_CALL;
    else if (ret)    cmd = C_RET;
    else if (branch) cmd = C_BRANCH;
    else if (inc)    cmd = C_INC;
  end

  assign empty   = (sp == '0);
  assign full    = (sp == SPW'(DEPTH));
  assign push    = (cmd == C_CALL) && !full;
  assign pop     = (cmd == C_RET) && !empty;
  assign wr_addr = AW'(sp);
  assign rd_addr = AW'(sp - SPW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // Clear first so a same-edge error set overrides it.
      if (clear_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (cmd == C_CALL && full)  overflow  <= 1'b1;
      if (cmd == C_RET  && empty) underflow <= 1'b1;

      case (cmd)
        C_LOAD, C_CALL: out <= d_in;
        C_RET:          if (!empty) out <= stack[rd_addr];
        C_BRANCH:       out <= out + offset;
        C_INC:          out <= out + STEP_W;
        default:        ;
      endcase

      if (push)     sp <= sp + SPW'(1);
      else if (pop) sp <= sp - SPW'(1);
    end
  end

  // Stack RAM is not reset; entries are only read below a valid sp.
  always_ff @(posedge clk) begin
    if (push) stack[wr_addr] <= out + STEP_W;
  end

endmodule

// File: tb/tb_pc_stack.sv
// Directed test-plan sequences plus random commands against a queue-based model.
module tb_pc_stack;
  localparam int W = 16;
  localparam int DEPTH = 8;
  localparam int STEP = 1;
  localparam int SPW = $clog2(DEPTH + 1);

  localparam logic [5:0] L = 6'b100000, C = 6'b010000, R = 6'b001000,
                         B = 6'b000100, I = 6'b000010, CE = 6'b000001;

  logic clk = 0, reset = 0;
  logic load = 0, call = 0, ret = 0, branch = 0, inc = 0, clear_err = 0;
  logic [W-1:0] d_in = '0, offset = '0;
  logic [W-1:0] out;
  logic [SPW-1:0] sp;
  logic empty, full, overflow, underflow;

  int total = 0, passed = 0;

  pc_stack #(.WIDTH(W), .DEPTH(DEPTH), .STEP(STEP)) dut (
    .clk(clk), .reset(reset), .load(load), .call(call), .ret(ret),
    .branch(branch), .inc(inc), .clear_err(clear_err), .d_in(d_in),
    .offset(offset), .out(out), .sp(sp), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: PC value, return stack as a queue, sticky flags.
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stk [$];
  bit m_ovf, m_unf;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = '0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      if (clear_err) begin m_ovf = 0; m_unf = 0; end
      if (load) m_pc = d_in;
      else if (call) begin
        if (m_stk.size() == DEPTH) m_ovf = 1;
        else m_stk.push_back(W'(m_pc + STEP));
        m_pc = d_in;
      end else if (ret) begin
        if (m_stk.size() == 0) m_unf = 1;
        else m_pc = m_stk.pop_back();
      end else if (branch) m_pc = W'(m_pc + offset);
      else if (inc) m_pc = W'(m_pc + STEP);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  always @(negedge clk) begin
    chk("m_out", 32'(out), 32'(m_pc));
    chk("m_sp", 32'(sp), 32'(m_stk.size()));
    chk("m_empty", 32'(empty), 32'(m_stk.size() == 0));
    chk("m_full", 32'(full), 32'(m_stk.size() == DEPTH));
    chk("m_ovf", 32'(overflow), 32'(m_ovf));
    chk("m_unf", 32'(underflow), 32'(m_unf));
  end

  // Drive a command set at the falling edge, return 1 time unit after the rising edge.
  task automatic op(input logic [5:0] c, input logic [W-1:0] d = '0, input logic [W-1:0] o = '0);
    @(negedge clk);
    {load, call, ret, branch, inc, clear_err} = c;
    d_in = d; offset = o;
    @(posedge clk); #1;
  endtask

  initial begin
    // 1. reset and mid-cycle async reset
    repeat (2) @(negedge clk);
    reset = 1;
    op(L, 16'h0055);
    chk("pre_reset_out", 32'(out), 32'h55);
    @(posedge clk); #3;
    load = 1; d_in = 16'd1123; reset = 0; #1;
    chk("async_out", 32'(out), 0);
    chk("async_sp", 32'(sp), 0);
    chk("async_empty", 32'(empty), 1);
    @(posedge clk); #1;
    chk("rst_hold_out", 32'(out), 0);
    chk("rst_hold_empty", 32'(empty), 1);
    @(negedge clk); reset = 1; load = 0;

    // 2. increment wrap
    op(L, 16'hFFFE);
    op(I); chk("inc_ffff", 32'(out), 32'hFFFF);
    op(I); chk("inc_wrap", 32'(out), 32'h0000);
    op(I); chk("inc_one", 32'(out), 32'h0001);

    // 3. call / return
    op(L, 16'd100);
    op(C, 16'd5678); chk("call_out", 32'(out), 5678); chk("call_sp", 32'(sp), 1);
    op(I); op(I); chk("inc2", 32'(out), 5680);
    op(R); chk("ret_out", 32'(out), 101); chk("ret_sp", 32'(sp), 0); chk("ret_empty", 32'(empty), 1);

    // 4. stack limits: pushes are 102, 1001, 1017, ..., 1097
    for (int k = 0; k < 9; k++) begin
      op(C, W'(1000 + k * 16));
      if (k == 7) begin chk("full8", 32'(full), 1); chk("no_ovf8", 32'(overflow), 0); end
    end
    chk("ovf_sp", 32'(sp), 8); chk("ovf_full", 32'(full), 1);
    chk("ovf_flag", 32'(overflow), 1); chk("ovf_out", 32'(out), 1000 + 8 * 16);
    for (int j = 0; j < 8; j++) begin
      op(R);
      chk("lifo", 32'(out), (j < 7) ? 32'(1000 + (6 - j) * 16 + 1) : 32'd102);
    end
    op(R);
    chk("unf_flag", 32'(underflow), 1); chk("unf_hold", 32'(out), 102); chk("unf_sp", 32'(sp), 0);
    op(CE);
    chk("clr_ovf", 32'(overflow), 0); chk("clr_unf", 32'(underflow), 0);

    // 5. branch
    op(L, 16'd10);
    op(B, '0, 16'hFFFD); chk("br_neg", 32'(out), 7);
    op(L, 16'h9000);
    op(B, '0, 16'h7FF0); chk("br_wrap", 32'(out), 32'h0FF0);

    // 6. priority
    op(C, 16'd200); op(C, 16'd300);
    op(L | C | R | I, 16'd9876); chk("pri_load", 32'(out), 9876); chk("pri_sp", 32'(sp), 2);
    op(R | B | I, '0, 16'd5); chk("pri_pop", 32'(out), 201); chk("pri_pop_sp", 32'(sp), 1);
    op(R); chk("pri_pop2", 32'(out), 32'h0FF1);
    op(R | CE); chk("set_wins", 32'(underflow), 1); chk("set_wins_sp", 32'(sp), 0);
    op(CE); chk("clr_after", 32'(underflow), 0);

    // random commands, model-checked every cycle
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] c;
      c[5] = ($urandom_range(99) < 8);
      c[4] = ($urandom_range(99) < 25);
      c[3] = ($urandom_range(99) < 25);
      c[2] = ($urandom_range(99) < 15);
      c[1] = ($urandom_range(99) < 30);
      c[0] = ($urandom_range(99) < 10);
      op(c, W'($urandom), W'($urandom));
    end

    op(6'b0);
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
